// File: rtl/adder_3_mux_pkg.sv
// Shared constants and result type for adder_3_mux.
// OPW is the operand width; res_t is the 3-bit {carry, sum} result.
package adder_3_mux_pkg;

  localparam int OPW = 2;

  typedef struct packed {
    logic           carry;
    logic [OPW-1:0] sum;
  } res_t;

endpackage

// File: rtl/adder_3_mux_fa_mux.sv
// Combinational full adder built only from 2:1 muxes.
// Ports: a, b, cin -> s, cout.
module fa_mux (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  // p is the propagate term (a != b).
  assign p    = a ? ~b : b;
  assign s    = p ? ~cin : cin;
  // When not propagating, a == b, so a is the generate.
  assign cout = p ? cin : a;

endmodule

// File: rtl/adder_3_mux.sv
// Registered 2-bit mux-based ripple adder, 1-cycle latency.
// Ports: clk, rst_n, a0, b0, a1, b1, c0 -> s1, s0, c2
// (+ sticky chk_err when ADDER_3_MUX_CHECK_EN is defined).
module adder_3_mux
  import adder_3_mux_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a0,
  input  logic b0,
  input  logic a1,
  input  logic b1,
  input  logic c0,
  output logic s1,
  output logic s0,
  output logic c2
`ifdef ADDER_3_MUX_CHECK_EN
  ,
  output logic chk_err
`endif
);

  logic c1;
  res_t sum_d;
  res_t sum_q;

  fa_mux u_fa0 (
    .a    (a0),
    .b    (b0),
    .cin  (c0),
    .s    (sum_d.sum[0]),
    .cout (c1)
  );

  fa_mux u_fa1 (
    .a    (a1),
    .b    (b1),
    .cin  (c1),
    .s    (sum_d.sum[1]),
    .cout (sum_d.carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign c2 = sum_q.carry;
  assign s1 = sum_q.sum[1];
  assign s0 = sum_q.sum[0];

`ifdef ADDER_3_MUX_CHECK_EN
  logic [OPW:0] ref_sum;

  assign ref_sum = {1'b0, a1, a0}
                 + {1'b0, b1, b0}
                 + {{OPW{1'b0}}, c0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err <= 1'b0;
    end else if (ref_sum != sum_d) begin
      chk_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_adder_3_mux.sv
// Directed self-checking bench for adder_3_mux.
// Drives operand sets and checks the registered result.
module tb_adder_3_mux;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic a0 = 1'b0;
  logic b0 = 1'b0;
  logic a1 = 1'b0;
  logic b1 = 1'b0;
  logic c0 = 1'b0;
  logic s1;
  logic s0;
  logic c2;
`ifdef ADDER_3_MUX_CHECK_EN
  logic chk_err;
`endif

  int passes = 0;
  int total = 0;

  adder_3_mux dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a0    (a0),
    .b0    (b0),
    .a1    (a1),
    .b1    (b1),
    .c0    (c0),
    .s1    (s1),
    .s0    (s0),
`ifdef ADDER_3_MUX_CHECK_EN
    .c2      (c2),
    .chk_err (chk_err)
`else
    .c2    (c2)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [2:0] exp);
    total++;
    assert ({c2, s1, s0} === exp) passes++;
    else $error("FAIL %s got %b exp %b",
                tag, {c2, s1, s0}, exp);
  endtask

  task automatic drive(input logic [1:0] a,
                       input logic [1:0] b,
                       input logic c);
    {a1, a0} = a;
    {b1, b0} = b;
    c0 = c;
  endtask

  task automatic step(input logic [1:0] a,
                      input logic [1:0] b,
                      input logic c,
                      input logic [2:0] exp,
                      input string tag);
    drive(a, b, c);
    @(posedge clk);
    #1;
    chk(tag, exp);
  endtask

  initial begin
    logic [2:0] e;
    drive(2'd3, 2'd3, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("rst_now", 3'b000);
    repeat (2) @(posedge clk);
    #1 chk("rst_held", 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    step(2'd0, 2'd2, 1'b1, 3'b011, "cc0");
    step(2'd1, 2'd2, 1'b1, 3'b100, "cc1");
    step(2'd3, 2'd2, 1'b1, 3'b110, "cc2");
    step(2'd3, 2'd0, 1'b1, 3'b100, "cc3");

    step(2'd3, 2'd0, 1'b0, 3'b011, "ci0");
    step(2'd3, 2'd0, 1'b1, 3'b100, "ci1");
    step(2'd3, 2'd1, 1'b1, 3'b101, "ci2");
    step(2'd3, 2'd3, 1'b1, 3'b111, "ci3");
    step(2'd1, 2'd3, 1'b1, 3'b101, "ci4");

    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      v = i[4:0];
      e = {1'b0, v[4:3]} + {1'b0, v[2:1]}
        + {2'b00, v[0]};
      step(v[4:3], v[2:1], v[0], e, "exh");
    end

    step(2'd3, 2'd3, 1'b1, 3'b111, "mid_pre");
    #2 drive(2'd2, 2'd1, 1'b0);
    rst_n = 1'b0;
    #1 chk("mid_rst", 3'b000);
    @(posedge clk);
    #1 chk("mid_hold", 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'd1, 2'd2, 1'b0);
    @(posedge clk);
    #1 chk("mid_rel", 3'b011);

    step(2'd2, 2'd2, 1'b0, 3'b100, "gl_pre");
    #2 c0 = 1'b1;
    #2 c0 = 1'b0;
    #1 chk("gl_mid", 3'b100);
    drive(2'd1, 2'd1, 1'b0);
    #1 c0 = 1'b1;
    #1 c0 = 1'b0;
    @(posedge clk);
    #1 chk("gl_post", 3'b010);

`ifdef ADDER_3_MUX_CHECK_EN
    total++;
    assert (chk_err === 1'b0) passes++;
    else $error("FAIL chk_err got %b exp 0",
                chk_err);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
